// File: rtl/onehot_dec_pkg.sv
// Shared types and decode helper for the one-hot to binary decoder.
package onehot_dec_pkg;

  localparam int unsigned ONE_HOT_W_DEF = 16;
  localparam int unsigned ERR_CNT_W_DEF = 8;
  localparam int unsigned OH_MAX_W      = 64;
  localparam int unsigned OH_IDX_W      = 6;

  typedef enum logic [1:0] {
    OH_OK    = 2'd0,
    OH_ZERO  = 2'd1,
    OH_MULTI = 2'd2
  } oh_status_e;

  typedef struct packed {
    logic [OH_IDX_W-1:0] idx;
    oh_status_e          status;
  } oh_dec_t;

  // Lowest set bit index plus classification, looking only at the low 'width' bits.
  function automatic oh_dec_t oh_decode(input logic [OH_MAX_W-1:0] vec,
                                        input int unsigned width);
    oh_dec_t res;
    int unsigned ones;
    res.idx    = '0;
    res.status = OH_OK;
    ones       = 0;
    for (int i = OH_MAX_W - 1; i >= 0; i--) begin
      if ((i < int'(width)) && vec[i]) begin
        ones    = ones + 1;
        res.idx = OH_IDX_W'(i);
      end
    end
    if (ones == 0) begin
      res.status = OH_ZERO;
    end else if (ones == 1) begin
      res.status = OH_OK;
    end else begin
      res.status = OH_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot_dec_skid.sv
// Two-entry valid/ready skid buffer with registered in_ready and out_valid.
module onehot_dec_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         accept;
  logic         deq;

  assign accept    = in_valid && in_ready_q;
  assign deq       = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  // Next state and data movement; the skid entry is only ever filled from ONE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deq) begin
          out_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deq) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and data registers; handshake flags are precomputed from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

endmodule

// File: rtl/onehot_to_bin_decoder.sv
// Streaming one-hot to binary index decoder with status, skid output and error count.
// Optional: define ONEHOT_DEC_ERR_CNT_EN to build the saturating error counter;
// otherwise err_cnt_o is tied to zero.
module onehot_to_bin_decoder
  import onehot_dec_pkg::*;
#(
  parameter int unsigned ONE_HOT_W = ONE_HOT_W_DEF,
  parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ONE_HOT_W-1:0]         one_hot_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [$clog2(ONE_HOT_W)-1:0] bin_o,
  output logic [1:0]                   status_o,
  output logic                         err_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
);

  localparam int unsigned BIN_W = $clog2(ONE_HOT_W);
  localparam int unsigned PAY_W = BIN_W + 2;

  oh_dec_t          dec;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;
  logic             unused_dec_idx;

  // Decode the word currently presented at the input.
  always_comb begin
    dec    = oh_decode(OH_MAX_W'(one_hot_i), ONE_HOT_W);
    in_pay = {dec.idx[BIN_W-1:0], dec.status};
  end

  assign unused_dec_idx = ^dec.idx;

  onehot_dec_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_data   (in_pay),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .out_data  (out_pay),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i)
  );

  assign bin_o    = out_pay[PAY_W-1:2];
  assign status_o = out_pay[1:0];
  assign err_o    = (oh_status_e'(out_pay[1:0]) != OH_OK);

`ifdef ONEHOT_DEC_ERR_CNT_EN
  logic                 accept;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign accept = in_valid_i && in_ready_o;

  // Count error words at acceptance, holding at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (accept && (dec.status != OH_OK) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule
